tetris_board: RTL

- Host-side board engine for the tetris player.
- Holds the 20x10 playfield and generates each tile for the player.
- Serves the player's row reads, then accepts its placement (col, rotation, set_tile).
- Drops the tile, locks it, clears full lines, and keeps score and game-over status.

---
 rtl/tetris_board.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tetris_board.sv
// tetris_board: 20x10 board engine -- tile generation, drop, lock, line clear, score and game-over.
module tetris_board #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter int          ROWS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        player_ready,
   output logic        host_ready,
   output logic [3:0]  tile_type,
   input  logic        row_req,
   input  logic [5:0]  row,
   output logic [9:0]  row_info,
   input  logic [3:0]  col,
   input  logic [1:0]  rotation,
   input  logic        set_tile,
   input  logic [3:0]  force_tile,
   output logic        place_err,
   output logic        game_over,
   output logic [15:0] lines_cleared,
   output logic [15:0] piece_count
);
   localparam int RW = $clog2(ROWS);
   typedef enum logic [2:0] {NEW, SPAWN, WAIT, CHECK, DROP, LOCK, CLEAR, OVER} state_t;
   state_t state, next;
   logic [9:0] board [ROWS];
   logic [15:0] lfsr, lfsr_next, sh;
   logic [RW-1:0] y, r;
   logic [3:0] col_q;
   logic [1:0] rot_q, bot;
   logic wide, hit0, hit1, can_drop, full, unused;

   function automatic logic [15:0] shape(input logic [3:0] t, input logic [1:0] rot);
      logic [15:0] s, q;
      int n;
      n = t == 4'd0 ? 4 : t == 4'd1 ? 2 : 3;
      s = t == 4'd0 ? 16'h00F0 : t == 4'd1 ? 16'h0033 : t == 4'd2 ? 16'h0072 : t == 4'd3 ? 16'h0036 :
          t == 4'd4 ? 16'h0063 : t == 4'd5 ? 16'h0071 : t == 4'd6 ? 16'h0074 : 16'h0000;
      for (int k = 0; k < 3; k++)
         if (k < int'(rot)) begin
            q = '0;
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  if (i < n && j < n) q[4'(i*4+j)] = s[4'((n-1-j)*4+i)];
            s = q;
         end
      return s;
   endfunction

   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign row_info = int'(row) < ROWS ? board[RW'(row)] : 10'd0;
   assign unused = row_req;

   // SPAWN tests the new tile at the last accepted col/rotation; cells beyond column 9 never collide
   always_comb begin
      sh = shape(tile_type, rot_q);
      bot = '0;
      wide = 1'b0;
      hit0 = 1'b0;
      hit1 = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (sh[4'(i*4+j)]) begin
               bot = 2'(i);
               if (int'(col_q) + j > 9) wide = 1'b1;
               else begin
                  if (i < ROWS && board[RW'(i)][4'(9-int'(col_q)-j)]) hit0 = 1'b1;
                  if (int'(y) + 1 + i < ROWS && board[RW'(int'(y)+1+i)][4'(9-int'(col_q)-j)]) hit1 = 1'b1;
               end
            end
      can_drop = int'(y) + int'(bot) + 1 <= ROWS - 1 && !hit1;
      full = board[r] == 10'h3FF;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= NEW;
      else state <= next;

   always_comb begin
      next = state;
      case (state)
         NEW:     if (player_ready && (force_tile < 4'd7 || lfsr_next[2:0] != 3'd7)) next = SPAWN;
         SPAWN:   next = hit0 ? OVER : WAIT;
         WAIT:    if (set_tile) next = CHECK;
         CHECK:   next = wide ? WAIT : DROP;
         DROP:    next = can_drop ? DROP : LOCK;
         LOCK:    next = CLEAR;
         CLEAR:   next = full ? CLEAR : r == '0 ? NEW : CLEAR;
         default: next = OVER;
      endcase
   end

   always_comb begin
      host_ready = state == WAIT;
      place_err = state == CHECK && wide;
      game_over = state == OVER;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int k = 0; k < ROWS; k++) board[k] <= '0;
         lfsr <= SEED;
         tile_type <= '0;
         col_q <= '0;
         rot_q <= '0;
         y <= '0;
         r <= '0;
         lines_cleared <= '0;
         piece_count <= '0;
      end else
         case (state)
            NEW: if (player_ready) begin
               lfsr <= lfsr_next;
               if (force_tile < 4'd7) tile_type <= force_tile;
               else if (lfsr_next[2:0] != 3'd7) tile_type <= {1'b0, lfsr_next[2:0]};
            end
            SPAWN: y <= '0;
            WAIT: if (set_tile) begin
               col_q <= col;
               rot_q <= rotation;
            end
            DROP: if (can_drop) y <= y + 1'b1;
            LOCK: begin
               for (int i = 0; i < 4; i++)
                  for (int j = 0; j < 4; j++)
                     if (sh[4'(i*4+j)] && int'(col_q) + j <= 9 && int'(y) + i < ROWS)
                        board[RW'(int'(y)+i)][4'(9-int'(col_q)-j)] <= 1'b1;
               piece_count <= piece_count + 1'b1;
               r <= RW'(ROWS - 1);
            end
            CLEAR: if (full) begin
               for (int k = 1; k < ROWS; k++)
                  if (k <= int'(r)) board[RW'(k)] <= board[RW'(k-1)];
               board[0] <= '0;
               lines_cleared <= lines_cleared + 1'b1;
            end else if (r != '0) r <= r - 1'b1;
            default: ;
         endcase
endmodule
